rr_arbiter_8: RTL

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/arb_pkg.sv | 6 +
 rtl/gnt_dec3to8.sv | 10 +
 rtl/rr_arbiter_8.sv | 81 ++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes and FSM state type for the round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/gnt_dec3to8.sv
// gnt_dec3to8: 3-to-8 one-hot decoder with enable; all zero when disabled.
module gnt_dec3to8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_dec
);
    assign o_dec = i_en ? N_REQ'(1) << i_idx : '0;
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with registered one-hot grant.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT grant cycles while others wait.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);
    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_ptr, r_idx, w_sel, w_cand;
    logic             w_rel, w_timeout;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    // Descending scan so the smallest offset from r_ptr is the last to win.
    always_comb begin
        w_sel  = r_ptr;
        w_cand = r_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = r_ptr + IDX_W'(k);
            if (req[w_cand]) w_sel = w_cand;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;

    assign w_timeout = (r_cnt == CW'(TIMEOUT)) && |(req & ~gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         r_cnt <= '0;
        else if (r_state == IDLE)        r_cnt <= |req ? CW'(1) : '0;
        else if (w_rel)                  r_cnt <= '0;
        else if (r_cnt != CW'(TIMEOUT))  r_cnt <= r_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_rel = done || !req[r_idx] || w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (|req ? GRANT : IDLE) : (w_rel ? IDLE : GRANT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_ptr <= '0;
        end else if (r_state == IDLE && |req) begin
            r_idx <= w_sel;
            r_ptr <= w_sel + 1'b1;
        end
    end

    always_comb begin
        gnt_vld = (r_state == GRANT);
        gnt_idx = r_idx;
    end

    gnt_dec3to8 u_dec (
        .i_idx (r_idx),
        .i_en  (gnt_vld),
        .o_dec (gnt)
    );
endmodule
